// File: rtl/nn_fixed_pkg.sv
// nn_fixed_pkg: shared Q8.8 fixed-point widths, constants, MAC states and saturating helpers.
package nn_fixed_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int FRACT_WIDTH = 8;
    localparam int ACC_WIDTH   = 32;

    localparam logic [DATA_WIDTH-1:0] ONE = 16'h0100;
    localparam logic signed [ACC_WIDTH:0] HALF_LSB = (ACC_WIDTH+1)'(1 << (FRACT_WIDTH-1));
    localparam logic signed [ACC_WIDTH:0] R_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] R_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_HOLD} mac_state_e;

    // Returns {overflow, saturated sum}.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic signed [ACC_WIDTH-1:0] a,
                                                   input logic signed [ACC_WIDTH-1:0] b);
        logic signed [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            return {1'b1, s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
        return {1'b0, s[ACC_WIDTH-1:0]};
    endfunction

    // Returns {clip, clamped value}.
    function automatic logic [DATA_WIDTH:0] clamp(input logic signed [ACC_WIDTH:0] r);
        if (r > R_MAX) return {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
        if (r < R_MIN) return {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
        return {1'b0, r[DATA_WIDTH-1:0]};
    endfunction
endpackage

// File: rtl/fixed_round_sat.sv
// fixed_round_sat: rounds a Q.16 accumulator half-up to Q8.8 and clamps it, flagging any clip.
module fixed_round_sat
    import nn_fixed_pkg::*;
(
    input  logic [ACC_WIDTH-1:0]  acc_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  clip_o
);
    logic signed [ACC_WIDTH:0] rounded;

    // One extra bit so the rounding add cannot wrap at the accumulator limit.
    always_comb begin
        rounded = ($signed({acc_i[ACC_WIDTH-1], acc_i}) + HALF_LSB) >>> FRACT_WIDTH;
        {clip_o, data_o} = clamp(rounded);
    end
endmodule

// File: rtl/neuron_mac_q8_8.sv
// neuron_mac_q8_8: streams (x,w) pairs, accumulates sum(x*w)+bias and emits a rounded, saturated Q8.8 word.
module neuron_mac_q8_8 #(
    parameter int DATA_WIDTH  = nn_fixed_pkg::DATA_WIDTH,
    parameter int FRACT_WIDTH = nn_fixed_pkg::FRACT_WIDTH,
    parameter int ACC_WIDTH   = nn_fixed_pkg::ACC_WIDTH,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_w,
    input  logic [DATA_WIDTH-1:0] in_bias,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sat,
    output logic [CNT_WIDTH-1:0]  out_terms
);
    import nn_fixed_pkg::*;

    mac_state_e              state_q, state_d;
    logic                    drain_q, drain_d, p_vld_q, p_vld_d, first_q, first_d;
    logic                    acc_sat_q, acc_sat_d, out_sat_q, out_sat_d;
    logic [2*DATA_WIDTH-1:0] p_q, p_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d, acc_base, add_sum;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d, rnd_data;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, out_terms_q, out_terms_d;
    logic                    add_ovf, xfer, take, clip, load;

    fixed_round_sat u_round (.acc_i(acc_q), .data_o(rnd_data), .clip_o(clip));

    assign in_ready  = state_q == ST_ACCUM;
    assign out_valid = state_q == ST_HOLD;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_terms = out_terms_q;

    always_comb begin
        xfer     = in_valid && in_ready;
        take     = out_valid && out_ready;
        // First term seeds the accumulator with the bias aligned to Q.16.
        acc_base = (xfer && first_q)
                 ? {{(ACC_WIDTH-DATA_WIDTH-FRACT_WIDTH){in_bias[DATA_WIDTH-1]}}, in_bias, {FRACT_WIDTH{1'b0}}}
                 : acc_q;
        {add_ovf, add_sum} = sat_add(acc_base, p_q);
        p_d      = xfer ? {{DATA_WIDTH{in_x[DATA_WIDTH-1]}}, in_x} * {{DATA_WIDTH{in_w[DATA_WIDTH-1]}}, in_w} : p_q;
        p_vld_d  = xfer;
        acc_d    = take ? '0 : p_vld_q ? add_sum : acc_base;
        acc_sat_d = take ? 1'b0 : acc_sat_q | (p_vld_q & add_ovf);
        first_d  = take | (first_q & ~xfer);
        cnt_d    = take ? '0 : (xfer && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        drain_d  = state_q == ST_DRAIN;
        load     = state_q == ST_DRAIN && drain_q;
        state_d  = (state_q == ST_ACCUM && xfer && in_last) ? ST_DRAIN
                 : load ? ST_HOLD
                 : take ? ST_ACCUM
                 : state_q;
        out_data_d  = load ? rnd_data : out_data_q;
        out_sat_d   = load ? clip | acc_sat_q : out_sat_q;
        out_terms_d = load ? cnt_q : out_terms_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ACCUM;
            drain_q     <= 1'b0;
            p_vld_q     <= 1'b0;
            first_q     <= 1'b1;
            acc_sat_q   <= 1'b0;
            p_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_terms_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            p_vld_q     <= p_vld_d;
            first_q     <= first_d;
            acc_sat_q   <= acc_sat_d;
            p_q         <= p_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_terms_q <= out_terms_d;
        end
    end
endmodule
